// File: rtl/pc_ctrl.sv
// Program counter controller with exception entry and a circular return-address stack.
// The next PC is chosen in this priority order: exception, stall, return, call, jump, branch,
// then sequential. A call made while the stack is full overwrites the oldest entry.
module pc_ctrl #(
  parameter int unsigned             WIDTH        = 32,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]        EXC_VECTOR   = 'h80,
  parameter int unsigned             RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc,
  input  logic             ret_en,
  input  logic             call_en,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic [WIDTH-1:0] branch_off,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             err
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] Four = {{(WIDTH-3){1'b0}}, 3'd4};

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             err_q, err_d;
  // sp_q points at the next free slot; the top entry lives at sp_q - 1.
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             push;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] jump_tgt;
  logic [PW-1:0]    sp_top;

  assign pc_plus4 = pc_q + Four;
  assign jump_tgt = {jump_addr[WIDTH-1:2], 2'b00};
  assign sp_top   = sp_q - PW'(1);

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign err       = err_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == DepthC);

  // Next-state selection by request priority.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    err_d = 1'b0;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (exc) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (!stall) begin
      if (ret_en) begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[sp_top];
          sp_d  = sp_top;
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Underflow: fall through sequentially and flag it.
          pc_d  = pc_plus4;
          err_d = 1'b1;
        end
      end else if (call_en) begin
        pc_d = jump_tgt;
        push = 1'b1;
        sp_d = sp_q + PW'(1);
        if (cnt_q == DepthC) begin
          // Full: the write slot holds the oldest entry, so it is overwritten.
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (jump_en) begin
        pc_d = jump_tgt;
      end else if (branch_en) begin
        pc_d = pc_plus4 + branch_off;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // State registers with synchronous reset; stack contents need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      err_q <= 1'b0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      err_q <= err_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (push) begin
        ras_q[sp_q] <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl at default parameters: a vector table plus hand-written corner sequences.
// Expected outputs are queued when each vector is driven and popped after the clock edge.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, exc, ret_en, call_en, jump_en, branch_en;
  logic [31:0] jump_addr, branch_off;
  logic [31:0] pc, epc;
  logic        ras_empty, ras_full, err;

  always #5 clk = ~clk;

  pc_ctrl #(
    .WIDTH       (32),
    .RESET_VECTOR(32'h0),
    .EXC_VECTOR  (32'h80),
    .RAS_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .exc       (exc),
    .ret_en    (ret_en),
    .call_en   (call_en),
    .jump_en   (jump_en),
    .branch_en (branch_en),
    .jump_addr (jump_addr),
    .branch_off(branch_off),
    .pc        (pc),
    .epc       (epc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .err       (err)
  );

  typedef struct {
    string       name;
    logic [6:0]  ctl;   // {rst, stall, exc, ret, call, jump, branch}
    logic [31:0] ja;
    logic [31:0] bo;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        emp;
    logic        full;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [6:0] IDLE = 7'b0000000, RST = 7'b1000000, STL = 7'b0100000;
  localparam logic [6:0] EXC = 7'b0010000, RET = 7'b0001000, CALL = 7'b0000100;
  localparam logic [6:0] JMP = 7'b0000010, BR = 7'b0000001;

  function automatic vec_t mk(input string n, input logic [6:0] c, input logic [31:0] ja,
                              input logic [31:0] bo, input logic [31:0] p, input logic [31:0] e,
                              input logic em, input logic fu, input logic er);
    vec_t v;
    v.name = n; v.ctl = c; v.ja = ja; v.bo = bo;
    v.pc = p; v.epc = e; v.emp = em; v.full = fu; v.err = er;
    return v;
  endfunction

  task automatic step(input vec_t v);
    vec_t x;
    @(negedge clk);
    {rst, stall, exc, ret_en, call_en, jump_en, branch_en} = v.ctl;
    jump_addr  = v.ja;
    branch_off = v.bo;
    sb.push_back(v);
    @(posedge clk);
    #1;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      x = sb.pop_front();
      if (pc === x.pc && epc === x.epc && ras_empty === x.emp && ras_full === x.full &&
          err === x.err) begin
        passed++;
      end else begin
        $display("FAIL %s: got pc=%h epc=%h empty=%b full=%b err=%b, want pc=%h epc=%h empty=%b full=%b err=%b",
                 x.name, pc, epc, ras_empty, ras_full, err, x.pc, x.epc, x.emp, x.full, x.err);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    {rst, stall, exc, ret_en, call_en, jump_en, branch_en} = 7'b0;
    jump_addr  = '0;
    branch_off = '0;

    // name, ctl, jump_addr, branch_off, pc, epc, empty, full, err
    vecs.push_back(mk("reset",        RST,  32'h0,        32'h0,        32'h0,        0, 1, 0, 0));
    vecs.push_back(mk("seq1",         IDLE, 32'h0,        32'h0,        32'h4,        0, 1, 0, 0));
    vecs.push_back(mk("seq2",         IDLE, 32'h0,        32'h0,        32'h8,        0, 1, 0, 0));
    vecs.push_back(mk("seq3",         IDLE, 32'h0,        32'h0,        32'hC,        0, 1, 0, 0));
    vecs.push_back(mk("seq4",         IDLE, 32'h0,        32'h0,        32'h10,       0, 1, 0, 0));
    vecs.push_back(mk("branch_back",  BR,   32'h0,        32'hFFFFFFF8, 32'hC,        0, 1, 0, 0));
    vecs.push_back(mk("jump_align",   JMP,  32'hFFFFFFFE, 32'h0,        32'hFFFFFFFC, 0, 1, 0, 0));
    vecs.push_back(mk("seq_wrap",     IDLE, 32'h0,        32'h0,        32'h0,        0, 1, 0, 0));
    vecs.push_back(mk("jump20",       JMP,  32'h20,       32'h0,        32'h20,       0, 1, 0, 0));
    vecs.push_back(mk("call103",      CALL, 32'h103,      32'h0,        32'h100,      0, 0, 0, 0));
    vecs.push_back(mk("ret1",         RET,  32'h0,        32'h0,        32'h24,       0, 1, 0, 0));
    vecs.push_back(mk("ret_under",    RET,  32'h0,        32'h0,        32'h28,       0, 1, 0, 1));
    vecs.push_back(mk("err_clear",    IDLE, 32'h0,        32'h0,        32'h2C,       0, 1, 0, 0));
    vecs.push_back(mk("jump0",        JMP,  32'h0,        32'h0,        32'h0,        0, 1, 0, 0));
    vecs.push_back(mk("call_a",       CALL, 32'h10,       32'h0,        32'h10,       0, 0, 0, 0));
    vecs.push_back(mk("call_b",       CALL, 32'h20,       32'h0,        32'h20,       0, 0, 0, 0));
    vecs.push_back(mk("call_c",       CALL, 32'h30,       32'h0,        32'h30,       0, 0, 0, 0));
    vecs.push_back(mk("call_d_full",  CALL, 32'h40,       32'h0,        32'h40,       0, 0, 1, 0));
    vecs.push_back(mk("call_over",    CALL, 32'h200,      32'h0,        32'h200,      0, 0, 1, 1));
    vecs.push_back(mk("stall_ret",    STL | RET, 32'h0,   32'h0,        32'h200,      0, 0, 1, 0));
    vecs.push_back(mk("ret_44",       RET,  32'h0,        32'h0,        32'h44,       0, 0, 0, 0));
    vecs.push_back(mk("ret_34",       RET,  32'h0,        32'h0,        32'h34,       0, 0, 0, 0));
    vecs.push_back(mk("ret_24",       RET,  32'h0,        32'h0,        32'h24,       0, 0, 0, 0));
    vecs.push_back(mk("ret_14",       RET,  32'h0,        32'h0,        32'h14,       0, 1, 0, 0));
    vecs.push_back(mk("ret_under2",   RET,  32'h0,        32'h0,        32'h18,       0, 1, 0, 1));
    vecs.push_back(mk("jump38",       JMP,  32'h38,       32'h0,        32'h38,       0, 1, 0, 0));
    vecs.push_back(mk("call3c",       CALL, 32'h3C,       32'h0,        32'h3C,       0, 0, 0, 0));
    vecs.push_back(mk("seq40",        IDLE, 32'h0,        32'h0,        32'h40,       0, 0, 0, 0));
    vecs.push_back(mk("exc_stall",    EXC | STL | CALL, 32'h500, 32'h0, 32'h80,      32'h40, 0, 0, 0));
    vecs.push_back(mk("call90",       CALL, 32'h90,       32'h0,        32'h90,       32'h40, 0, 0, 0));
    vecs.push_back(mk("rst_mid",      RST | CALL, 32'h300, 32'h0,       32'h0,        0, 1, 0, 0));
    vecs.push_back(mk("post_rst",     IDLE, 32'h0,        32'h0,        32'h4,        0, 1, 0, 0));
    vecs.push_back(mk("ras_cleared",  RET,  32'h0,        32'h0,        32'h8,        0, 1, 0, 1));
    vecs.push_back(mk("br_pos",       BR | JMP, 32'h700,  32'h10,       32'h700,      0, 1, 0, 0));
    vecs.push_back(mk("br_fwd",       BR,   32'h0,        32'h10,       32'h714,      0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Multi-cycle stall and exception interplay after a reset held with stall asserted.
    step(mk("hs_rst_stall", RST | STL, 32'h0, 32'h0, 32'h0,  0,      1, 0, 0));
    step(mk("hs_stall",     STL,       32'h0, 32'h0, 32'h0,  0,      1, 0, 0));
    step(mk("hs_stall_br",  STL | BR,  32'h0, 32'h40, 32'h0, 0,      1, 0, 0));
    step(mk("hs_stall_ret", STL | RET, 32'h0, 32'h0, 32'h0,  0,      1, 0, 0));
    step(mk("hs_exc",       EXC,       32'h0, 32'h0, 32'h80, 32'h0,  1, 0, 0));
    step(mk("hs_exc_again", EXC | STL, 32'h0, 32'h0, 32'h80, 32'h80, 1, 0, 0));
    step(mk("hs_resume",    IDLE,      32'h0, 32'h0, 32'h84, 32'h80, 1, 0, 0));

    // Wrap of the circular stack: six pushes leave the last four, popped newest first.
    step(mk("wr_j",  JMP,  32'h1000, 32'h0, 32'h1000, 32'h80, 1, 0, 0));
    for (int k = 1; k <= 6; k++) begin
      step(mk("wr_call", CALL, 32'h1000 + 32'(k) * 32'h100, 32'h0, 32'h1000 + 32'(k) * 32'h100,
              32'h80, 0, (k >= 4), (k >= 5)));
    end
    for (int k = 5; k >= 2; k--) begin
      step(mk("wr_ret", RET, 32'h0, 32'h0, 32'h1004 + 32'(k) * 32'h100, 32'h80,
              (k == 2), 0, 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
